// File: rtl/wb_sequencer.sv
// wb_sequencer: writeback controller driving the regfile write mux select and write enable
// Ports: clk, reset_n (async active-low); req_valid/req_ready/req_src/req_rd request
// handshake from the control FSM; src_ready per-source data valid; flush sync abort;
// memtoreg/reg_write/wr_addr registered regfile controls; done/busy/err_timeout status.
// Optional macro WB_TIMEOUT_EN abandons a WAIT after TIMEOUT_CYCLES cycles.
module wb_sequencer #(
  parameter int NUM_SRC = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_src,
  input  logic [4:0]         req_rd,
  input  logic [NUM_SRC-1:0] src_ready,
  input  logic               flush,
  output logic [2:0]         memtoreg,
  output logic               reg_write,
  output logic [4:0]         wr_addr,
  output logic               done,
  output logic               busy,
  output logic               err_timeout
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;
  state_t state, state_d;
  logic [4:0] rd_q;
  logic accept, rdy_req, rdy_cur, tmo;
  assign req_ready = (state != WAIT) & ~flush;
  assign accept = req_valid & req_ready;
  // memtoreg doubles as the captured source; source 7 is a constant and always ready
  assign rdy_req = src_ready[req_src] | (&req_src);
  assign rdy_cur = src_ready[memtoreg] | (&memtoreg);
`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // rdy_cur gates the timeout so a coinciding ready still writes
  assign tmo = (state == WAIT) & ~rdy_cur & (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      err_timeout <= tmo;
    end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_comb begin
    state_d = IDLE;
    if (accept)
      state_d = (req_rd == 5'd0) ? IDLE : rdy_req ? WRITE : WAIT;
    else if (state == WAIT)
      state_d = (flush | tmo) ? IDLE : rdy_cur ? WRITE : WAIT;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      memtoreg <= 3'd0;
      rd_q <= 5'd0;
      reg_write <= 1'b0;
      wr_addr <= 5'd0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      memtoreg <= accept ? req_src : memtoreg;
      rd_q <= accept ? req_rd : rd_q;
      reg_write <= state_d == WRITE;
      wr_addr <= (state_d == WRITE) ? (accept ? req_rd : rd_q) : wr_addr;
      done <= (state_d == WRITE) | (accept & (req_rd == 5'd0));
      busy <= state_d != IDLE;
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed checks of wb_sequencer accept, wait, back-to-back, flush and reset
module tb_wb_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, flush = 1'b0;
  logic [2:0] req_src = 3'd0;
  logic [4:0] req_rd = 5'd0;
  logic [7:0] src_ready = 8'd0;
  logic req_ready, reg_write, done, busy, err_timeout;
  logic [2:0] memtoreg;
  logic [4:0] wr_addr;
  int passed = 0, total = 0;
  wb_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_rd(req_rd), .src_ready(src_ready), .flush(flush),
    .memtoreg(memtoreg), .reg_write(reg_write), .wr_addr(wr_addr), .done(done),
    .busy(busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic req(input logic [2:0] s, input logic [4:0] r, input logic [7:0] rdy);
    req_valid = 1'b1;
    req_src = s;
    req_rd = r;
    src_ready = rdy;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_memtoreg", memtoreg, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", req_ready, 1);
    req(3'd5, 5'd8, 8'h20);
    tick();
    req_valid = 1'b0;
    chk("t1_memtoreg", memtoreg, 5);
    chk("t1_reg_write", reg_write, 1);
    chk("t1_wr_addr", wr_addr, 8);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_rw_off", reg_write, 0);
    chk("t1_done_off", done, 0);
    chk("t1_busy_off", busy, 0);
    req(3'd1, 5'd3, 8'h00);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_wait_busy", busy, 1);
      chk("t2_wait_ready", req_ready, 0);
      chk("t2_wait_rw", reg_write, 0);
      chk("t2_wait_memtoreg", memtoreg, 1);
      if (i == 3) src_ready = 8'h02;
      tick();
    end
    src_ready = 8'h00;
    chk("t2_reg_write", reg_write, 1);
    chk("t2_wr_addr", wr_addr, 3);
    chk("t2_memtoreg", memtoreg, 1);
    chk("t2_done", done, 1);
    tick();
    chk("t2_rw_off", reg_write, 0);
    req(3'd7, 5'd31, 8'h00);
    tick();
    chk("t3_reg_write", reg_write, 1);
    chk("t3_memtoreg", memtoreg, 7);
    chk("t3_wr_addr", wr_addr, 31);
    req(3'd5, 5'd0, 8'h20);
    tick();
    req_valid = 1'b0;
    chk("t3_rd0_done", done, 1);
    chk("t3_rd0_rw", reg_write, 0);
    chk("t3_rd0_busy", busy, 0);
    chk("t3_rd0_addr", wr_addr, 31);
    chk("t3_rd0_mux", memtoreg, 5);
    tick();
    chk("t3_rd0_done_off", done, 0);
    chk("t3_rd0_rw_off", reg_write, 0);
    req(3'd5, 5'd4, 8'h24);
    tick();
    chk("t4_rw_a", reg_write, 1);
    chk("t4_addr_a", wr_addr, 4);
    chk("t4_ready_write", req_ready, 1);
    req(3'd2, 5'd5, 8'h24);
    tick();
    req_valid = 1'b0;
    chk("t4_rw_b", reg_write, 1);
    chk("t4_addr_b", wr_addr, 5);
    chk("t4_mux_b", memtoreg, 2);
    tick();
    chk("t4_rw_off", reg_write, 0);
    req(3'd6, 5'd9, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t5_wait_busy", busy, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_busy", busy, 0);
    chk("t5_flush_rw", reg_write, 0);
    chk("t5_flush_done", done, 0);
    #1;
    chk("t5_flush_ready", req_ready, 1);
    tick();
    chk("t5_flush_rw2", reg_write, 0);
    req(3'd5, 5'd12, 8'h20);
    tick();
    chk("t6_rw", reg_write, 1);
    chk("t6_addr", wr_addr, 12);
    flush = 1'b1;
    req(3'd5, 5'd13, 8'h20);
    #1;
    chk("t6_flush_noready", req_ready, 0);
    tick();
    chk("t6_after_rw", reg_write, 0);
    chk("t6_after_done", done, 0);
    chk("t6_after_busy", busy, 0);
    chk("t6_after_addr", wr_addr, 12);
    req(3'd5, 5'd14, 8'h20);
    tick();
    chk("t7_idle_flush_rw", reg_write, 0);
    chk("t7_idle_flush_busy", busy, 0);
    flush = 1'b0;
    req(3'd1, 5'd7, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("t8_wait_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_mux", memtoreg, 0);
    reset_n = 1'b1;
    src_ready = 8'h02;
    tick();
    chk("t8_no_write", reg_write, 0);
    tick();
    chk("t8_no_write2", reg_write, 0);
    src_ready = 8'h00;
`ifdef WB_TIMEOUT_EN
    req(3'd1, 5'd3, 8'h00);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_busy", busy, 1);
      chk("to_wait_err", err_timeout, 0);
    end
    tick();
    chk("to_err", err_timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_rw", reg_write, 0);
    chk("to_done", done, 0);
    chk("to_ready", req_ready, 1);
    tick();
    chk("to_err_off", err_timeout, 0);
`else
    chk("no_timeout_err", err_timeout, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
Writeback controller for the multicycle core. It takes one writeback request per instruction from the main control FSM and waits until the selected data source is valid. It then drives the 3-bit writeback-source select for the 8-input register-file data mux and issues a single-cycle register write to the destination register. It sits between the control unit and the register file / writeback mux, and replaces the control FSM's direct driving of memtoreg and regwrite.

Parameters:
NUM_SRC, 8, number of writeback sources; fixed select width 3.
TIMEOUT_CYCLES, 16, WAIT cycles before abandon; used only with WB_TIMEOUT_EN.

Ports:
clk  input  1  core clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  control FSM presents a writeback request
req_ready  output  1  sequencer accepts request this cycle
req_src  input  3  source select: 000 RegB, 001 Load, 010 Shift, 011 PC, 100 LUI-ext, 101 ALUOut, 110 MDR, 111 const 227
req_rd  input  5  destination register index
src_ready  input  8  per-source data-valid, bit i = source i
flush  input  1  synchronous abort (exception/branch squash)
memtoreg  output  3  registered select to the writeback mux
reg_write  output  1  registered register-file write enable, 1-cycle pulse
wr_addr  output  5  registered register-file write address
done  output  1  1-cycle pulse: request retired, with or without write
busy  output  1  high in WAIT or WRITE
err_timeout  output  1  1-cycle pulse: request abandoned on timeout

Behaviour:
- Reset (async, reset_n=0): state=IDLE; memtoreg=000, reg_write=0, wr_addr=0, done=0, busy=0, err_timeout=0, captured src/rd=0. Reset mid-WAIT or mid-WRITE drops the request and performs no write.
- States are IDLE, WAIT and WRITE. All outputs except req_ready are registered. req_ready is combinational: 1 in IDLE and WRITE, 0 in WAIT, and forced 0 whenever flush=1.
- Accept: the request is accepted when req_valid & req_ready. The sequencer captures src and rd and loads memtoreg<=req_src on the same edge, so the mux settles before the write.
- Effective ready: rdy = src_ready[src] | (src==111). Source 111 is always ready; src_ready[7] is ignored.
- On accept with rd==0: no write. done pulses next cycle and state goes to IDLE (register $0 is never written).
- On accept with rd!=0 and rdy this cycle: next state is WRITE. Latency is req accept to reg_write = 1 cycle.
- On accept with rd!=0 and !rdy: next state is WAIT.
- WAIT: memtoreg holds the captured src. The cycle rdy is sampled high, the next state is WRITE.
- WRITE: reg_write=1, wr_addr=rd, done=1 for exactly one cycle. A new request may be accepted in the same cycle (back-to-back). The next state then follows the accept rules above; otherwise it is IDLE. Sustained throughput is one write per cycle.
- flush in WAIT: return to IDLE, no write, done=0.
- flush in WRITE: the in-flight write still completes. A request presented in the same cycle is not accepted.
- flush in IDLE: no effect except blocking accept.
- In IDLE, memtoreg and wr_addr hold their last values; reg_write=0.
- Source index width is exactly 3 bits; no out-of-range case exists.

Optional Feature:
WB_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When the count reaches TIMEOUT_CYCLES with rdy still 0:
  - next state IDLE, no write;
  - err_timeout pulses 1 cycle and done stays 0.
  - If rdy and the timeout coincide, the write wins.
- Not defined: WAIT lasts indefinitely, err_timeout is tied 0, and no counter is synthesized.

Test Plan:
- Reset, then req_valid=1, src=101, rd=8, src_ready=8'h20 -> next cycle memtoreg=101, reg_write=1, wr_addr=8, done=1; following cycle reg_write=0.
- src=001, rd=3, src_ready=0 for 4 cycles, then bit1=1 -> busy=1 for 4 cycles, req_ready=0 throughout WAIT, reg_write one cycle after bit1 rises, wr_addr=3, memtoreg=001.
- src=111, rd=31, src_ready=0 -> write next cycle, memtoreg=111; also rd=0 with src=101 -> done=1, reg_write never asserted.
- Back-to-back: accept (101, rd=4), then during WRITE accept (010, rd=5) with bit2=1 -> consecutive reg_write cycles, wr_addr 4 then 5.
- flush while WAITing on src 110 -> IDLE, no reg_write, no done; flush during WRITE -> write to rd completes and a simultaneous new req is not accepted.
- With WB_TIMEOUT_EN, TIMEOUT_CYCLES=16: src=001 never ready -> err_timeout pulses after 16 WAIT cycles, no reg_write, state IDLE, req_ready=1.
